// File: rtl/ex_alu_pkg.sv
// Shared definitions for the integer execute stage: openum encodings,
// zero/boolean constants, divider FSM states and op-class helpers.
package ex_alu_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [31:0] ZERO_WORD = '0;
  localparam logic [4:0]  ZERO_ROB  = '0;

  localparam logic [5:0] OPENUM_NOP    = 6'd0;
  localparam logic [5:0] OPENUM_LUI    = 6'd1;
  localparam logic [5:0] OPENUM_AUIPC  = 6'd2;
  localparam logic [5:0] OPENUM_JAL    = 6'd3;
  localparam logic [5:0] OPENUM_JALR   = 6'd4;
  localparam logic [5:0] OPENUM_BEQ    = 6'd5;
  localparam logic [5:0] OPENUM_BNE    = 6'd6;
  localparam logic [5:0] OPENUM_BLT    = 6'd7;
  localparam logic [5:0] OPENUM_BGE    = 6'd8;
  localparam logic [5:0] OPENUM_BLTU   = 6'd9;
  localparam logic [5:0] OPENUM_BGEU   = 6'd10;
  localparam logic [5:0] OPENUM_ADDI   = 6'd11;
  localparam logic [5:0] OPENUM_SLTI   = 6'd12;
  localparam logic [5:0] OPENUM_SLTIU  = 6'd13;
  localparam logic [5:0] OPENUM_XORI   = 6'd14;
  localparam logic [5:0] OPENUM_ORI    = 6'd15;
  localparam logic [5:0] OPENUM_ANDI   = 6'd16;
  localparam logic [5:0] OPENUM_SLLI   = 6'd17;
  localparam logic [5:0] OPENUM_SRLI   = 6'd18;
  localparam logic [5:0] OPENUM_SRAI   = 6'd19;
  localparam logic [5:0] OPENUM_ADD    = 6'd20;
  localparam logic [5:0] OPENUM_SUB    = 6'd21;
  localparam logic [5:0] OPENUM_SLL    = 6'd22;
  localparam logic [5:0] OPENUM_SLT    = 6'd23;
  localparam logic [5:0] OPENUM_SLTU   = 6'd24;
  localparam logic [5:0] OPENUM_XOR    = 6'd25;
  localparam logic [5:0] OPENUM_SRL    = 6'd26;
  localparam logic [5:0] OPENUM_SRA    = 6'd27;
  localparam logic [5:0] OPENUM_OR     = 6'd28;
  localparam logic [5:0] OPENUM_AND    = 6'd29;
  localparam logic [5:0] OPENUM_MUL    = 6'd30;
  localparam logic [5:0] OPENUM_MULH   = 6'd31;
  localparam logic [5:0] OPENUM_MULHSU = 6'd32;
  localparam logic [5:0] OPENUM_MULHU  = 6'd33;
  localparam logic [5:0] OPENUM_DIV    = 6'd34;
  localparam logic [5:0] OPENUM_DIVU   = 6'd35;
  localparam logic [5:0] OPENUM_REM    = 6'd36;
  localparam logic [5:0] OPENUM_REMU   = 6'd37;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

  function automatic logic is_mul_op(input logic [5:0] op);
    return op inside {OPENUM_MUL, OPENUM_MULH, OPENUM_MULHSU, OPENUM_MULHU};
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return op inside {OPENUM_DIV, OPENUM_DIVU, OPENUM_REM, OPENUM_REMU};
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider with start/busy/done handshake.
// Signed operands are folded to magnitudes on entry and fixed up on the way out.
module ex_div
  import ex_alu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_signed,
  input  logic                is_rem,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [DATA_LEN-1:0] result
);

  localparam int CNT_W = $clog2(DATA_LEN);

  div_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_LEN-1:0] rem, quo, dvs;
  logic [DATA_LEN-1:0] abs_a, abs_b, diff;
  logic [DATA_LEN:0]   shifted;
  logic                fits;
  logic                rem_op, neg_q, neg_r;

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start) state_nxt = DIV_RUN;
      DIV_RUN:  if (cnt == CNT_W'(DATA_LEN - 1)) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != DIV_IDLE);
    done   = (state == DIV_DONE);
    result = rem_op ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  end

  always_comb begin
    abs_a   = (is_signed && dividend[DATA_LEN-1]) ? -dividend : dividend;
    abs_b   = (is_signed && divisor[DATA_LEN-1])  ? -divisor  : divisor;
    shifted = {rem, quo[DATA_LEN-1]};
    fits    = (shifted >= {1'b0, dvs});
    diff    = shifted[DATA_LEN-1:0] - dvs;
  end

  // A zero divisor runs the normal loop (all-ones quotient, remainder = dividend);
  // only the quotient sign fix-up is suppressed so signed div-by-zero stays all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      rem_op <= FALSE;
      neg_q  <= FALSE;
      neg_r  <= FALSE;
    end else if (state == DIV_IDLE && start) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= abs_a;
      dvs    <= abs_b;
      rem_op <= is_rem;
      neg_q  <= is_signed && (dividend[DATA_LEN-1] ^ divisor[DATA_LEN-1]) && (divisor != '0);
      neg_r  <= is_signed && dividend[DATA_LEN-1];
    end else if (state == DIV_RUN) begin
      rem <= fits ? diff : shifted[DATA_LEN-1:0];
      quo <= {quo[DATA_LEN-2:0], fits};
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ex_alu.sv
// Integer execute stage: computes RV32I results/branch outcomes and broadcasts on the CDB.
// Define RV32M_EN to add the 2-cycle multiplier and the iterative divider (ex_div).
module ex_alu
  import ex_alu_pkg::*;
#(
  parameter int DATA_LEN   = 32,
  parameter int OPENUM_LEN = 6,
  parameter int ROB_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_in,
  input  logic [OPENUM_LEN-1:0] openum_in,
  input  logic [DATA_LEN-1:0]   V1_in,
  input  logic [DATA_LEN-1:0]   V2_in,
  input  logic [DATA_LEN-1:0]   pc_in,
  input  logic [DATA_LEN-1:0]   imm_in,
  input  logic [ROB_LEN:0]      rob_id_in,
  output logic                  busy_out,
  output logic                  valid_out,
  output logic [ROB_LEN:0]      rob_id_out,
  output logic [DATA_LEN-1:0]   result_out,
  output logic                  jump_out,
  output logic [DATA_LEN-1:0]   target_pc_out
);

  logic                issue, alu_issue, is_imm, alu_jmp;
  logic [DATA_LEN-1:0] src2, alu_res, alu_tgt, jalr_sum;
  logic [4:0]          shamt;

  always_comb begin
    is_imm   = openum_in inside {OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI,
                                 OPENUM_ANDI, OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI};
    src2     = is_imm ? imm_in : V2_in;
    shamt    = src2[4:0];
    jalr_sum = V1_in + imm_in;
    alu_res  = ZERO_WORD;
    alu_jmp  = FALSE;
    alu_tgt  = ZERO_WORD;
    case (openum_in)
      OPENUM_LUI:   alu_res = imm_in;
      OPENUM_AUIPC: alu_res = pc_in + imm_in;
      OPENUM_JAL: begin
        alu_res = pc_in + DATA_LEN'(4);
        alu_jmp = TRUE;
        alu_tgt = pc_in + imm_in;
      end
      OPENUM_JALR: begin
        alu_res = pc_in + DATA_LEN'(4);
        alu_jmp = TRUE;
        alu_tgt = jalr_sum & ~DATA_LEN'(1);
      end
      OPENUM_BEQ:  begin alu_tgt = pc_in + imm_in; alu_jmp = (V1_in == V2_in); end
      OPENUM_BNE:  begin alu_tgt = pc_in + imm_in; alu_jmp = (V1_in != V2_in); end
      OPENUM_BLT:  begin alu_tgt = pc_in + imm_in; alu_jmp = ($signed(V1_in) <  $signed(V2_in)); end
      OPENUM_BGE:  begin alu_tgt = pc_in + imm_in; alu_jmp = ($signed(V1_in) >= $signed(V2_in)); end
      OPENUM_BLTU: begin alu_tgt = pc_in + imm_in; alu_jmp = (V1_in <  V2_in); end
      OPENUM_BGEU: begin alu_tgt = pc_in + imm_in; alu_jmp = (V1_in >= V2_in); end
      OPENUM_ADDI, OPENUM_ADD:  alu_res = V1_in + src2;
      OPENUM_SUB:               alu_res = V1_in - V2_in;
      OPENUM_SLTI, OPENUM_SLT:  alu_res = DATA_LEN'($signed(V1_in) < $signed(src2));
      OPENUM_SLTIU, OPENUM_SLTU: alu_res = DATA_LEN'(V1_in < src2);
      OPENUM_XORI, OPENUM_XOR:  alu_res = V1_in ^ src2;
      OPENUM_ORI, OPENUM_OR:    alu_res = V1_in | src2;
      OPENUM_ANDI, OPENUM_AND:  alu_res = V1_in & src2;
      OPENUM_SLLI, OPENUM_SLL:  alu_res = V1_in << shamt;
      OPENUM_SRLI, OPENUM_SRL:  alu_res = V1_in >> shamt;
      OPENUM_SRAI, OPENUM_SRA:  alu_res = DATA_LEN'($signed(V1_in) >>> shamt);
      default: ;
    endcase
  end

  assign issue = (openum_in != OPENUM_NOP) && !busy_out && !flush_in;

`ifdef RV32M_EN
  logic                  is_mul, is_div, mul_vld, div_start, div_busy, div_done, div_rst;
  logic [OPENUM_LEN-1:0] mul_op;
  logic [DATA_LEN-1:0]   mul_a, mul_b, mul_res, div_res;
  logic [ROB_LEN:0]      mul_tag, div_tag;
  logic [2*DATA_LEN-1:0] mul_a_ext, mul_b_ext, mul_prod;

  assign is_mul    = is_mul_op(openum_in);
  assign is_div    = is_div_op(openum_in);
  assign busy_out  = mul_vld | div_busy;
  assign alu_issue = issue & ~is_mul & ~is_div;
  assign div_start = issue & is_div;
  assign div_rst   = rst | flush_in;

  // Stage 1 captures operands; the product lands in the output register next edge.
  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      mul_vld <= FALSE;
      mul_op  <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_tag <= '0;
    end else begin
      mul_vld <= issue & is_mul;
      if (issue && is_mul) begin
        mul_op  <= openum_in;
        mul_a   <= V1_in;
        mul_b   <= V2_in;
        mul_tag <= rob_id_in;
      end
    end
  end

  always_comb begin
    mul_a_ext = (mul_op == OPENUM_MULH || mul_op == OPENUM_MULHSU) ?
                {{DATA_LEN{mul_a[DATA_LEN-1]}}, mul_a} : {{DATA_LEN{1'b0}}, mul_a};
    mul_b_ext = (mul_op == OPENUM_MULH) ?
                {{DATA_LEN{mul_b[DATA_LEN-1]}}, mul_b} : {{DATA_LEN{1'b0}}, mul_b};
    mul_prod  = mul_a_ext * mul_b_ext;
    mul_res   = (mul_op == OPENUM_MUL) ? mul_prod[DATA_LEN-1:0] : mul_prod[2*DATA_LEN-1:DATA_LEN];
  end

  always_ff @(posedge clk) begin
    if (rst || flush_in) div_tag <= '0;
    else if (div_start)  div_tag <= rob_id_in;
  end

  ex_div #(.DATA_LEN(DATA_LEN)) u_div (
    .clk       (clk),
    .rst       (div_rst),
    .start     (div_start),
    .is_signed (openum_in == OPENUM_DIV || openum_in == OPENUM_REM),
    .is_rem    (openum_in == OPENUM_REM || openum_in == OPENUM_REMU),
    .dividend  (V1_in),
    .divisor   (V2_in),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_res)
  );
`else
  assign busy_out  = FALSE;
  assign alu_issue = issue;
`endif

  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      valid_out     <= FALSE;
      rob_id_out    <= ZERO_ROB;
      result_out    <= ZERO_WORD;
      jump_out      <= FALSE;
      target_pc_out <= ZERO_WORD;
    end else if (alu_issue) begin
      valid_out     <= TRUE;
      rob_id_out    <= rob_id_in;
      result_out    <= alu_res;
      jump_out      <= alu_jmp;
      target_pc_out <= alu_tgt;
`ifdef RV32M_EN
    end else if (mul_vld) begin
      valid_out     <= TRUE;
      rob_id_out    <= mul_tag;
      result_out    <= mul_res;
      jump_out      <= FALSE;
      target_pc_out <= ZERO_WORD;
    end else if (div_done) begin
      valid_out     <= TRUE;
      rob_id_out    <= div_tag;
      result_out    <= div_res;
      jump_out      <= FALSE;
      target_pc_out <= ZERO_WORD;
`endif
    end else begin
      valid_out  <= FALSE;
      rob_id_out <= ZERO_ROB;
    end
  end

endmodule

// File: tb/tb_ex_alu.sv
// Self-checking bench for ex_alu: directed cases plus random issue streams against a reference model.
// M-extension scenarios are exercised when RV32M_EN is defined.
module tb_ex_alu;
  import ex_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush_in;
  logic [5:0]  openum_in;
  logic [31:0] V1_in, V2_in, pc_in, imm_in;
  logic [4:0]  rob_id_in;
  logic        busy_out, valid_out, jump_out;
  logic [4:0]  rob_id_out;
  logic [31:0] result_out, target_pc_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        jmp;
    logic [31:0] tgt;
  } exp_t;

  always #5 clk = ~clk;

  ex_alu #(.DATA_LEN(32), .OPENUM_LEN(6), .ROB_LEN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_in      (flush_in),
    .openum_in     (openum_in),
    .V1_in         (V1_in),
    .V2_in         (V2_in),
    .pc_in         (pc_in),
    .imm_in        (imm_in),
    .rob_id_in     (rob_id_in),
    .busy_out      (busy_out),
    .valid_out     (valid_out),
    .rob_id_out    (rob_id_out),
    .result_out    (result_out),
    .jump_out      (jump_out),
    .target_pc_out (target_pc_out)
  );

  always @(posedge clk) begin
    if (rst === 1'b0 && flush_in === 1'b0 && openum_in !== OPENUM_NOP && busy_out === 1'b1) begin
      errors++;
      $display("FAIL protocol: issue of op %0d while busy_out=1", openum_in);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, b, pc, imm);
    exp_t e;
    logic [31:0] s2;
    int sh;
    e  = '0;
    s2 = (op inside {OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI,
                     OPENUM_ANDI, OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI}) ? imm : b;
    sh = int'(s2[4:0]);
    if (op inside {OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU})
      e.tgt = pc + imm;
    case (op)
      OPENUM_LUI:   e.res = imm;
      OPENUM_AUIPC: e.res = pc + imm;
      OPENUM_JAL:   begin e.res = pc + 32'd4; e.jmp = 1'b1; e.tgt = pc + imm; end
      OPENUM_JALR:  begin e.res = pc + 32'd4; e.jmp = 1'b1; e.tgt = (a + imm) & 32'hFFFF_FFFE; end
      OPENUM_BEQ:   e.jmp = (a == b);
      OPENUM_BNE:   e.jmp = (a != b);
      OPENUM_BLT:   e.jmp = ($signed(a) <  $signed(b));
      OPENUM_BGE:   e.jmp = ($signed(a) >= $signed(b));
      OPENUM_BLTU:  e.jmp = (a <  b);
      OPENUM_BGEU:  e.jmp = (a >= b);
      OPENUM_ADDI, OPENUM_ADD:   e.res = a + s2;
      OPENUM_SUB:                e.res = a - b;
      OPENUM_SLTI, OPENUM_SLT:   e.res = ($signed(a) < $signed(s2)) ? 32'd1 : 32'd0;
      OPENUM_SLTIU, OPENUM_SLTU: e.res = (a < s2) ? 32'd1 : 32'd0;
      OPENUM_XORI, OPENUM_XOR:   e.res = a ^ s2;
      OPENUM_ORI, OPENUM_OR:     e.res = a | s2;
      OPENUM_ANDI, OPENUM_AND:   e.res = a & s2;
      OPENUM_SLLI, OPENUM_SLL:   e.res = a << sh;
      OPENUM_SRLI, OPENUM_SRL:   e.res = a >> sh;
      OPENUM_SRAI, OPENUM_SRA:   e.res = 32'($signed(a) >>> sh);
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] m_model(input logic [5:0] op, input logic [31:0] a, b);
    logic [63:0] p;
    longint sa, sb, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      OPENUM_MUL:    return a * b;
      OPENUM_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OPENUM_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OPENUM_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OPENUM_DIV:
        if (b == 0) return 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        else return 32'($signed(a) / $signed(b));
      OPENUM_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OPENUM_REM:
        if (b == 0) return a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        else return 32'($signed(a) % $signed(b));
      OPENUM_REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, b, pc, imm, input logic [4:0] tag);
    openum_in = op; V1_in = a; V2_in = b; pc_in = pc; imm_in = imm; rob_id_in = tag;
  endtask

  task automatic idle();
    openum_in = OPENUM_NOP;
  endtask

  // Waits (bounded) for valid_out; lat counts edges from the accepting edge.
  task automatic wait_valid(input int limit, output int lat, output logic busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (valid_out !== 1'b1 && lat < limit) begin
      if (busy_out !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_in = 1'b0; idle();
    drive(OPENUM_NOP, 0, 0, 0, 0, 0);
    step(); step();
    checks++;
    if ({valid_out, rob_id_out, result_out, jump_out, target_pc_out, busy_out} !== '0) begin
      errors++;
      $display("FAIL reset: got v=%b tag=%0d res=%h j=%b tgt=%h busy=%b, expected all zero",
               valid_out, rob_id_out, result_out, jump_out, target_pc_out, busy_out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    drive(OPENUM_ADDI, 32'd5, 32'd0, 32'h0, 32'hFFFF_FFF9, 5'd3);
    step(); idle();
    checks++;
    if ({valid_out, rob_id_out, result_out, jump_out, target_pc_out} !== {1'b1, 5'd3, 32'hFFFF_FFFE, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL addi: got v=%b tag=%0d res=%h j=%b tgt=%h, expected v=1 tag=3 res=fffffffe j=0 tgt=0",
               valid_out, rob_id_out, result_out, jump_out, target_pc_out);
    end
    drive(OPENUM_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd5);
    step();
    checks++;
    if ({valid_out, rob_id_out, result_out, jump_out, target_pc_out} !== {1'b1, 5'd5, 32'h0, 1'b1, 32'h120}) begin
      errors++;
      $display("FAIL blt_taken: got v=%b tag=%0d res=%h j=%b tgt=%h, expected v=1 tag=5 res=0 j=1 tgt=120",
               valid_out, rob_id_out, result_out, jump_out, target_pc_out);
    end
    drive(OPENUM_BLT, 32'd2, 32'd1, 32'h100, 32'h20, 5'd6);
    step();
    checks++;
    if ({valid_out, rob_id_out, result_out, jump_out} !== {1'b1, 5'd6, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL blt_not_taken: got v=%b tag=%0d res=%h j=%b, expected v=1 tag=6 res=0 j=0",
               valid_out, rob_id_out, result_out, jump_out);
    end
    drive(OPENUM_JALR, 32'h1003, 32'd0, 32'h40, 32'd4, 5'd7);
    step(); idle();
    checks++;
    if ({valid_out, rob_id_out, result_out, jump_out, target_pc_out} !== {1'b1, 5'd7, 32'h44, 1'b1, 32'h1006}) begin
      errors++;
      $display("FAIL jalr: got v=%b tag=%0d res=%h j=%b tgt=%h, expected v=1 tag=7 res=44 j=1 tgt=1006",
               valid_out, rob_id_out, result_out, jump_out, target_pc_out);
    end
    step();
    checks++;
    if ({valid_out, rob_id_out, result_out, jump_out, target_pc_out} !== {1'b0, 5'd0, 32'h44, 1'b1, 32'h1006}) begin
      errors++;
      $display("FAIL hold: got v=%b tag=%0d res=%h j=%b tgt=%h, expected v=0 tag=0 res=44 j=1 tgt=1006",
               valid_out, rob_id_out, result_out, jump_out, target_pc_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [3];
    exp_t e;
    ops = '{OPENUM_ADD, OPENUM_SUB, OPENUM_SLL};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 32'h1234_5678, 32'h0000_0F0F, 32'h200, 32'h0, 5'(i + 10));
      e = model(ops[i], 32'h1234_5678, 32'h0000_0F0F, 32'h200, 32'h0);
      step();
      checks++;
      if ({valid_out, rob_id_out, result_out, jump_out} !== {1'b1, 5'(i + 10), e.res, 1'b0}) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b tag=%0d res=%h j=%b, expected v=1 tag=%0d res=%h j=0",
                 i, valid_out, rob_id_out, result_out, jump_out, i + 10, e.res);
      end
    end
    idle();
    step();
    checks++;
    if ({valid_out, rob_id_out} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL b2b_end: got v=%b tag=%0d, expected v=0 tag=0", valid_out, rob_id_out);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [5:0]  op;
    logic [31:0] a, b, pc, imm;
    logic [4:0]  tag, exp_rob;
    logic        exp_vld, exp_jmp;
    logic [31:0] exp_res, exp_tgt;
    rst = 1'b1; step(); rst = 1'b0;
    exp_res = '0; exp_jmp = 1'b0; exp_tgt = '0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) begin
`ifdef RV32M_EN
        op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(38, 63)) : 6'($urandom_range(1, 29));
`else
        op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(30, 63)) : 6'($urandom_range(1, 29));
`endif
        a   = $urandom;
        b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
        pc  = $urandom & 32'hFFFF_FFFC;
        imm = 32'($urandom_range(0, 4095));
        if (imm[11]) imm = imm | 32'hFFFF_F000;
        if ($urandom_range(0, 3) == 0) imm = $urandom;
        tag = 5'($urandom_range(1, 31));
        drive(op, a, b, pc, imm, tag);
        e = model(op, a, b, pc, imm);
        exp_vld = 1'b1; exp_rob = tag; exp_res = e.res; exp_jmp = e.jmp; exp_tgt = e.tgt;
      end else begin
        idle();
        op = OPENUM_NOP;
        exp_vld = 1'b0; exp_rob = 5'd0;
      end
      step();
      checks++;
      if ({valid_out, rob_id_out, result_out, jump_out, target_pc_out} !==
          {exp_vld, exp_rob, exp_res, exp_jmp, exp_tgt}) begin
        errors++;
        $display("FAIL random[%0d] op=%0d: got v=%b tag=%0d res=%h j=%b tgt=%h, expected v=%b tag=%0d res=%h j=%b tgt=%h",
                 i, op, valid_out, rob_id_out, result_out, jump_out, target_pc_out,
                 exp_vld, exp_rob, exp_res, exp_jmp, exp_tgt);
      end
    end
    idle();
    step();
  endtask

  task automatic test_flush();
    drive(OPENUM_ADD, 32'd1, 32'd2, 32'h0, 32'h0, 5'd4);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0; idle();
    checks++;
    if ({valid_out, rob_id_out, result_out, jump_out, target_pc_out, busy_out} !== '0) begin
      errors++;
      $display("FAIL flush_issue: got v=%b tag=%0d res=%h j=%b tgt=%h busy=%b, expected all zero",
               valid_out, rob_id_out, result_out, jump_out, target_pc_out, busy_out);
    end
    drive(OPENUM_JAL, 32'd0, 32'd0, 32'h80, 32'h10, 5'd8);
    step(); idle();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    checks++;
    if ({valid_out, rob_id_out, result_out, jump_out, target_pc_out} !== '0) begin
      errors++;
      $display("FAIL flush_after: got v=%b tag=%0d res=%h j=%b tgt=%h, expected all zero",
               valid_out, rob_id_out, result_out, jump_out, target_pc_out);
    end
  endtask

`ifdef RV32M_EN
  task automatic test_mul();
    int lat;
    logic busy_ok;
    logic [5:0]  op;
    logic [31:0] a, b, exp;
    drive(OPENUM_MULH, 32'h8000_0000, 32'd2, 32'h0, 32'h0, 5'd7);
    step(); idle();
    wait_valid(10, lat, busy_ok);
    checks++;
    if (lat != 2 || !busy_ok || rob_id_out !== 5'd7 || result_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mulh: got lat=%0d busy_ok=%b tag=%0d res=%h, expected lat=2 busy_ok=1 tag=7 res=ffffffff",
               lat, busy_ok, rob_id_out, result_out);
    end
    for (int i = 0; i < 12; i++) begin
      op = 6'($urandom_range(30, 33));
      a = $urandom; b = $urandom;
      exp = m_model(op, a, b);
      drive(op, a, b, 32'h0, 32'h0, 5'(i + 1));
      step(); idle();
      wait_valid(10, lat, busy_ok);
      checks++;
      if (lat != 2 || rob_id_out !== 5'(i + 1) || result_out !== exp || jump_out !== 1'b0) begin
        errors++;
        $display("FAIL mul_rand[%0d] op=%0d a=%h b=%h: got lat=%0d tag=%0d res=%h j=%b, expected lat=2 tag=%0d res=%h j=0",
                 i, op, a, b, lat, rob_id_out, result_out, jump_out, i + 1, exp);
      end
    end
  endtask

  task automatic test_div();
    int lat;
    logic busy_ok;
    logic [5:0]  op;
    logic [31:0] a, b, exp;
    drive(OPENUM_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd9);
    step(); idle();
    wait_valid(60, lat, busy_ok);
    checks++;
    if (lat != 34 || !busy_ok || rob_id_out !== 5'd9 || result_out !== 32'h8000_0000 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL div_ovf: got lat=%0d busy_ok=%b tag=%0d res=%h busy=%b, expected lat=34 busy_ok=1 tag=9 res=80000000 busy=0",
               lat, busy_ok, rob_id_out, result_out, busy_out);
    end
    drive(OPENUM_REMU, 32'd7, 32'd0, 32'h0, 32'h0, 5'd12);
    step(); idle();
    wait_valid(60, lat, busy_ok);
    checks++;
    if (lat != 34 || rob_id_out !== 5'd12 || result_out !== 32'd7) begin
      errors++;
      $display("FAIL remu_zero: got lat=%0d tag=%0d res=%h, expected lat=34 tag=12 res=7",
               lat, rob_id_out, result_out);
    end
    for (int i = 0; i < 8; i++) begin
      op = 6'($urandom_range(34, 37));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 100));
        2: b = -32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      exp = m_model(op, a, b);
      drive(op, a, b, 32'h0, 32'h0, 5'(i + 20));
      step(); idle();
      wait_valid(60, lat, busy_ok);
      checks++;
      if (lat != 34 || !busy_ok || rob_id_out !== 5'(i + 20) || result_out !== exp) begin
        errors++;
        $display("FAIL div_rand[%0d] op=%0d a=%h b=%h: got lat=%0d busy_ok=%b tag=%0d res=%h, expected lat=34 busy_ok=1 tag=%0d res=%h",
                 i, op, a, b, lat, busy_ok, rob_id_out, result_out, i + 20, exp);
      end
    end
  endtask

  task automatic test_flush_div();
    logic seen;
    exp_t e;
    drive(OPENUM_DIVU, 32'd1000, 32'd7, 32'h0, 32'h0, 5'd15);
    step(); idle();
    repeat (9) step();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_div: got busy=%b v=%b, expected busy=0 v=0", busy_out, valid_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid_out === 1'b1 || busy_out === 1'b1) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_div_ghost: got late valid/busy=%b, expected 0", seen);
    end
    drive(OPENUM_ADD, 32'd40, 32'd2, 32'h0, 32'h0, 5'd16);
    e = model(OPENUM_ADD, 32'd40, 32'd2, 32'h0, 32'h0);
    step(); idle();
    checks++;
    if ({valid_out, rob_id_out, result_out} !== {1'b1, 5'd16, e.res}) begin
      errors++;
      $display("FAIL flush_div_add: got v=%b tag=%0d res=%h, expected v=1 tag=16 res=%h",
               valid_out, rob_id_out, result_out, e.res);
    end
  endtask
`else
  task automatic test_m_undefined();
    logic [5:0] ops [2];
    ops = '{OPENUM_MUL, OPENUM_DIV};
    for (int i = 0; i < 2; i++) begin
      drive(ops[i], 32'd6, 32'd3, 32'h10, 32'h4, 5'(i + 4));
      step(); idle();
      checks++;
      if ({busy_out, valid_out, rob_id_out, result_out, jump_out, target_pc_out} !==
          {1'b0, 1'b1, 5'(i + 4), 32'h0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL m_undef[%0d]: got busy=%b v=%b tag=%0d res=%h j=%b tgt=%h, expected busy=0 v=1 tag=%0d res=0 j=0 tgt=0",
                 i, busy_out, valid_out, rob_id_out, result_out, jump_out, target_pc_out, i + 4);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
`ifdef RV32M_EN
    test_mul();
    test_div();
    test_flush_div();
`else
    test_m_undefined();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_alu.md
# ex_alu

Integer execute stage fed directly by the reservation station. It accepts one issued operation per cycle (openum, operands, pc, imm, ROB tag) and computes the ALU result, branch/jump outcome and target. It broadcasts the result on the RS CDB one cycle later, or later for multi-cycle ops. When built with the M extension, it adds a 2-cycle multiplier and an iterative divider, and stalls issue through `busy_out`.

## Interface
Parameters:
- DATA_LEN, 32: operand/result width.
- OPENUM_LEN, 6: opcode enum width.
- ROB_LEN, 4: ROB tag width is ROB_LEN+1; tag 0 = none.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush_in  in  1  commit jump flag from ROB; same effect as rst on this block.
- openum_in  in  OPENUM_LEN  issued op; OPENUM_NOP = no issue.
- V1_in, V2_in  in  DATA_LEN  source operands.
- pc_in  in  DATA_LEN  instruction pc.
- imm_in  in  DATA_LEN  sign-extended immediate.
- rob_id_in  in  ROB_LEN+1  destination ROB tag.
- busy_out  out  1  high = RS must not issue this cycle (M ops in flight).
- valid_out  out  1  CDB broadcast valid, one-cycle pulse per op.
- rob_id_out  out  ROB_LEN+1  tag of broadcast result.
- result_out  out  DATA_LEN  rd value (pc+4 for JAL/JALR; 0 for branches).
- jump_out  out  1  taken (branches) / always 1 (JAL, JALR).
- target_pc_out  out  DATA_LEN  redirect pc.

## Operation
- Issue accepted when openum_in != OPENUM_NOP and busy_out == 0. Issue while busy_out == 1 is a protocol violation; the op is dropped and a bench assertion fires.
- RV32I ops (LUI, AUIPC, JAL, JALR, BEQ..BGEU, ADD[I]..SRA[I], SLT[U][I]) are computed combinationally and registered once.
- Targets:
  - JAL and branches: pc+imm.
  - JALR: (V1+imm) & ~1.
  - Non-control ops: target_pc_out = 0 and jump_out = 0.
- Immediate ops use imm_in; register ops use V2_in. Shift amount = low 5 bits. All arithmetic is mod 2^32.
- Undefined openum: broadcast result 0 with its tag; no jump.
- Outputs hold their last values when valid_out == 0, except rob_id_out, which is 0.

## Timing
- Reset/flush values: valid_out 0, rob_id_out 0, result_out 0, jump_out 0, target_pc_out 0, busy_out 0, divider FSM IDLE.
- RV32I latency: op accepted at edge N, valid_out high for the cycle after edge N.
- Flush at an edge cancels every in-flight op. No valid_out follows from any op accepted before or at that edge.
- Flush has priority over a simultaneous issue or divider completion.

## Configuration
- RV32M_EN defined:
  - MUL/MULH/MULHSU/MULHU: latency 2; busy_out high for 1 cycle after accept.
  - DIV/DIVU/REM/REMU: FSM IDLE -> RUN (32 cycles, radix-2 restoring) -> DONE (1 cycle broadcast) -> IDLE; latency 34; busy_out high from the cycle after accept until DONE inclusive.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV 0x80000000 / -1: quotient 0x80000000, remainder 0.
  - Signed ops correct operand and result signs around the unsigned core.
- RV32M_EN undefined: M openums are treated as undefined (result 0, latency 1); busy_out is tied 0; no multiplier or divider logic is present.

## Structure
- openum constants, ZERO_WORD, ZERO_ROB and TRUE/FALSE live in the shared defines header. No new local opcode encodings.
- One sub-module, ex_div: iterative divider with start/busy/done, signed fix-up inside. It is instantiated only under RV32M_EN.
- The multiplier is inline as a two-stage register.

## Test plan
- ADDI: V1=5, imm=-7, tag 3 -> next cycle valid_out=1, result 0xFFFFFFFE, rob_id 3, jump 0.
- BLT: V1=-1, V2=1, pc=0x100, imm=0x20 -> jump 1, target 0x120, result 0. With V1=2 -> jump 0.
- JALR: pc=0x40, V1=0x1003, imm=4 -> result 0x44, target 0x1006, jump 1.
- Back-to-back issue of ADD, SUB, SLL on consecutive cycles -> three consecutive valid pulses, in order, with the correct tags.
- RV32M_EN:
  - DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000 after 34 cycles; busy_out high throughout.
  - REMU 7/0 -> 7.
  - MULH 0x80000000 * 2 -> 0xFFFFFFFF at latency 2.
- Flush mid-divide (cycle 10 of RUN) -> busy_out 0 and valid_out 0 the next cycle. A subsequent ADD completes normally at latency 1.
